// File: rtl/rvc_pkg.sv
// Constants shared by the RVC compressor, packer and the core's expander.
package rvc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [15:0] RVC_NOP    = 16'h0001;
  localparam logic [15:0] RVC_EBREAK = 16'h9002;
  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam logic [31:0] RV_EBREAK  = 32'h0010_0073;

  typedef enum logic [0:0] {
    StEmpty,
    StHalf
  } pack_state_e;

  // True for x8..x15, the registers reachable through a 3-bit RVC field.
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC mapper; first matching rule wins, otherwise no compression.
module rvc_compressor
  import rvc_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_compressed_o,
  output logic [15:0] cinstr_o
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        imm_i_small;
  logic        lw_off_ok;
  logic        sw_off_ok;
  logic        alu_ok;
  logic [1:0]  alu_f2;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign imm_i  = instr_i[31:20];
  assign imm_s  = {instr_i[31:25], instr_i[11:7]};

  // Fits a 6-bit signed immediate when bits [11:5] are all sign copies.
  assign imm_i_small = (&imm_i[11:5]) | ~(|imm_i[11:5]);
  assign lw_off_ok   = (imm_i[11:8] == 4'h0) && (imm_i[1:0] == 2'b00);
  assign sw_off_ok   = (imm_s[11:8] == 4'h0) && (imm_s[1:0] == 2'b00);

  always_comb begin
    alu_ok = 1'b0;
    alu_f2 = 2'b00;
    if (opcode == OP && rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
      if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
        alu_ok = 1'b1;
        alu_f2 = 2'b00;
      end else if (funct7 == 7'b0000000) begin
        unique case (funct3)
          3'b100:  begin alu_ok = 1'b1; alu_f2 = 2'b01; end
          3'b110:  begin alu_ok = 1'b1; alu_f2 = 2'b10; end
          3'b111:  begin alu_ok = 1'b1; alu_f2 = 2'b11; end
          default: alu_ok = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    is_compressed_o = 1'b1;
    cinstr_o        = 16'h0000;
    if (instr_i == RV_NOP) begin
      cinstr_o = RVC_NOP;
    end else if (opcode == OP_IMM && funct3 == 3'b000 && rd == rs1 && rd != 5'd0 &&
                 imm_i != 12'd0 && imm_i_small) begin
      cinstr_o = {3'b000, imm_i[5], rd, imm_i[4:0], C_Q1};
    end else if (opcode == OP_IMM && funct3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 &&
                 imm_i_small) begin
      cinstr_o = {3'b010, imm_i[5], rd, imm_i[4:0], C_Q1};
    end else if (opcode == OP && funct3 == 3'b000 && funct7 == 7'd0 && rs1 == 5'd0 &&
                 rd != 5'd0 && rs2 != 5'd0) begin
      cinstr_o = {3'b100, 1'b0, rd, rs2, C_Q2};
    end else if (opcode == OP && funct3 == 3'b000 && funct7 == 7'd0 && rd == rs1 &&
                 rd != 5'd0 && rs2 != 5'd0) begin
      cinstr_o = {3'b100, 1'b1, rd, rs2, C_Q2};
    end else if (alu_ok) begin
      cinstr_o = {3'b100, 1'b0, 2'b11, rd[2:0], alu_f2, rs2[2:0], C_Q1};
    end else if (opcode == LOAD && funct3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                 lw_off_ok) begin
      cinstr_o = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], C_Q2};
    end else if (opcode == STORE && funct3 == 3'b010 && rs1 == 5'd2 && sw_off_ok) begin
      cinstr_o = {3'b110, imm_s[5:2], imm_s[7:6], rs2, C_Q2};
    end else if (opcode == SYSTEM && instr_i == RV_EBREAK) begin
      cinstr_o = RVC_EBREAK;
    end else begin
      is_compressed_o = 1'b0;
    end
  end

endmodule

// File: rtl/compressed_instruction_packer.sv
// Compresses an RV32I stream where possible and packs 16/32-bit results into 32-bit words.
module compressed_instruction_packer
  import rvc_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_word,
  output logic [COUNT_WIDTH-1:0] compressed_count,
  output logic [COUNT_WIDTH-1:0] total_count
);

  pack_state_e            state_q, state_d;
  logic [15:0]            hold_q, hold_d;
  logic [31:0]            out_word_q, out_word_d;
  logic                   out_valid_q, out_valid_d;
  logic                   flush_done_q, flush_done_d;
  logic [COUNT_WIDTH-1:0] comp_cnt_q, comp_cnt_d;
  logic [COUNT_WIDTH-1:0] total_cnt_q, total_cnt_d;

  logic        is_comp;
  logic [15:0] cinstr;
  logic        accept;
  logic        flush_go;

  rvc_compressor u_compressor (
    .instr_i         (in_instruction),
    .is_compressed_o (is_comp),
    .cinstr_o        (cinstr)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Instructions win over flush; flush only acts on an idle input cycle.
  assign flush_go = !in_valid && flush && in_ready;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    out_word_d   = out_word_q;
    out_valid_d  = out_valid_q && !out_ready;
    flush_done_d = 1'b0;
    comp_cnt_d   = comp_cnt_q;
    total_cnt_d  = total_cnt_q;

    if (accept) begin
      total_cnt_d = total_cnt_q + COUNT_WIDTH'(1);
      if (is_comp) begin
        comp_cnt_d = comp_cnt_q + COUNT_WIDTH'(1);
      end
      unique case (state_q)
        StEmpty: begin
          if (is_comp) begin
            hold_d  = cinstr;
            state_d = StHalf;
          end else begin
            out_word_d  = in_instruction;
            out_valid_d = 1'b1;
          end
        end
        StHalf: begin
          out_valid_d = 1'b1;
          if (is_comp) begin
            out_word_d = {cinstr, hold_q};
            state_d    = StEmpty;
          end else begin
            out_word_d = {in_instruction[15:0], hold_q};
            hold_d     = in_instruction[31:16];
          end
        end
      endcase
    end else if (flush_go) begin
      flush_done_d = 1'b1;
      if (state_q == StHalf) begin
        out_word_d  = {RVC_NOP, hold_q};
        out_valid_d = 1'b1;
        state_d     = StEmpty;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      hold_q       <= 16'h0000;
      out_word_q   <= 32'h0000_0000;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      comp_cnt_q   <= '0;
      total_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      out_word_q   <= out_word_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
      comp_cnt_q   <= comp_cnt_d;
      total_cnt_q  <= total_cnt_d;
    end
  end

  assign out_word         = out_word_q;
  assign out_valid        = out_valid_q;
  assign flush_done       = flush_done_q;
  assign compressed_count = comp_cnt_q;
  assign total_count      = total_cnt_q;

endmodule

// File: tb/tb_compressed_instruction_packer.sv
// Randomized bench for the packer against a halfword-queue reference model.
module tb_compressed_instruction_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [15:0] compressed_count;
  logic [15:0] total_count;

  compressed_instruction_packer #(.COUNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instruction   (in_instruction),
    .flush            (flush),
    .flush_done       (flush_done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .compressed_count (compressed_count),
    .total_count      (total_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] hq[$];
  logic [31:0] wq[$];
  logic [15:0] m_total = 16'd0;
  logic [15:0] m_comp  = 16'd0;
  bit          exp_fd  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference RVC mapping written as field arithmetic on ints.
  function automatic void ref_compress(input logic [31:0] i, output bit c,
                                       output logic [15:0] h);
    int opc, rd, f3, rs1, rs2, f7, imm, simm, f2;
    opc = int'(i[6:0]);  rd = int'(i[11:7]); f3 = int'(i[14:12]);
    rs1 = int'(i[19:15]); rs2 = int'(i[24:20]); f7 = int'(i[31:25]);
    imm  = int'($signed(i[31:20]));
    simm = int'($signed({i[31:25], i[11:7]}));
    f2 = -1;
    if (opc == 'h33 && rd == rs1 && rd >= 8 && rd <= 15 && rs2 >= 8 && rs2 <= 15) begin
      if (f7 == 'h20 && f3 == 0) f2 = 0;
      else if (f7 == 0 && f3 == 4) f2 = 1;
      else if (f7 == 0 && f3 == 6) f2 = 2;
      else if (f7 == 0 && f3 == 7) f2 = 3;
    end
    c = 1'b1;
    h = 16'h0;
    if (i == 32'h13) h = 16'h0001;
    else if (opc == 'h13 && f3 == 0 && rd == rs1 && rd != 0 && imm != 0 && imm >= -32 &&
             imm <= 31)
      h = 16'((((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1);
    else if (opc == 'h13 && f3 == 0 && rs1 == 0 && rd != 0 && imm >= -32 && imm <= 31)
      h = 16'((2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1);
    else if (opc == 'h33 && f3 == 0 && f7 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
      h = 16'((4 << 13) | (rd << 7) | (rs2 << 2) | 2);
    else if (opc == 'h33 && f3 == 0 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
      h = 16'((4 << 13) | (1 << 12) | (rd << 7) | (rs2 << 2) | 2);
    else if (f2 >= 0)
      h = 16'((4 << 13) | (3 << 10) | ((rd - 8) << 7) | (f2 << 5) | ((rs2 - 8) << 2) | 1);
    else if (opc == 'h03 && f3 == 2 && rs1 == 2 && rd != 0 && imm >= 0 && imm <= 252 &&
             imm % 4 == 0)
      h = 16'((2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | (((imm >> 2) & 7) << 4) |
              (((imm >> 6) & 3) << 2) | 2);
    else if (opc == 'h23 && f3 == 2 && rs1 == 2 && simm >= 0 && simm <= 252 && simm % 4 == 0)
      h = 16'((6 << 13) | (((simm >> 2) & 15) << 9) | (((simm >> 6) & 3) << 7) |
              (rs2 << 2) | 2);
    else if (i == 32'h0010_0073) h = 16'h9002;
    else c = 1'b0;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd2;
      2:       return 5'($urandom_range(8, 15));
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rd  = pick_reg();
    rs1 = ($urandom_range(0, 1) == 1) ? rd : pick_reg();
    rs2 = pick_reg();
    case ($urandom_range(0, 2))
      0:       imm = 12'($urandom_range(0, 80) - 40);
      1:       imm = 12'($urandom_range(0, 72) * 4);
      default: imm = 12'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0: return {imm, rs1, 3'b000, rd, 7'b0010011};
      1: return {imm, 5'd0, 3'b000, rd, 7'b0010011};
      2: return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
      3: begin
        case ($urandom_range(0, 3))
          0:       begin f3 = 3'b000; f7 = 7'b0100000; end
          1:       begin f3 = 3'b100; f7 = 7'd0; end
          2:       begin f3 = 3'b110; f7 = 7'd0; end
          default: begin f3 = 3'b111; f7 = 7'd0; end
        endcase
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
      end
      4: return {imm, 5'd2, 3'b010, rd, 7'b0000011};
      5: return {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'b0100011};
      6: return 32'h0010_0073;
      7: return 32'h0000_0013;
      8: return {20'($urandom), rd, 7'b0110111};
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit ordy);
    bit          exp_rdy, acc, fgo, c;
    logic [15:0] h;
    in_valid = v; in_instruction = ins; flush = fl; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (wq.size() == 0) || ordy;
    check_eq("out_valid", out_valid, 32'(wq.size() != 0));
    check_eq("in_ready", in_ready, 32'(exp_rdy));
    check_eq("flush_done", flush_done, 32'(exp_fd));
    check_eq("total_count", total_count, m_total);
    check_eq("compressed_count", compressed_count, m_comp);
    if (wq.size() != 0 && ordy) begin
      check_eq("out_word", out_word, wq[0]);
      void'(wq.pop_front());
    end
    acc    = v && exp_rdy;
    fgo    = !v && fl && exp_rdy;
    exp_fd = fgo;
    if (acc) begin
      ref_compress(ins, c, h);
      m_total++;
      if (c) begin
        m_comp++;
        hq.push_back(h);
      end else begin
        hq.push_back(ins[15:0]);
        hq.push_back(ins[31:16]);
      end
    end else if (fgo && hq.size() == 1) begin
      hq.push_back(16'h0001);
    end
    while (hq.size() >= 2) begin
      wq.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    hq.delete();
    wq.delete();
    m_total = 16'd0;
    m_comp  = 16'd0;
    exp_fd  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instruction = 32'h0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_out_word", out_word, 32'd0);
    check_eq("rst_flush_done", flush_done, 32'd0);
    check_eq("rst_counts", {compressed_count, total_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two compressible addi forms pack into one word.
    step(1'b1, 32'h0055_0513, 1'b0, 1'b1);
    step(1'b1, 32'hFFF0_0593, 1'b0, 1'b1);
    check_eq("t1_word", out_word, 32'h55FD_0515);
    check_eq("t1_comp", compressed_count, 32'd2);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    step(1'b1, 32'h1234_52B7, 1'b0, 1'b1);
    check_eq("t2_word", out_word, 32'h1234_52B7);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    step(1'b1, 32'h00B5_0533, 1'b0, 1'b1);
    step(1'b1, 32'h1234_52B7, 1'b0, 1'b1);
    check_eq("t3_word", out_word, 32'h52B7_952E);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("t3_flush_word", out_word, 32'h0001_1234);
    check_eq("t3_flush_done", flush_done, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    step(1'b1, 32'h0081_2403, 1'b0, 1'b1);
    step(1'b1, 32'h0010_0073, 1'b0, 1'b1);
    check_eq("t4_word", out_word, 32'h9002_4422);
    step(1'b1, 32'h1001_2403, 1'b0, 1'b1);
    check_eq("t4_lw256", out_word, 32'h1001_2403);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    step(1'b1, 32'h1234_52B7, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
      check_eq("t5_hold_word", out_word, 32'h1234_52B7);
      check_eq("t5_in_ready", in_ready, 32'd0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset while HALF with a word pending.
    step(1'b1, 32'h00B5_0533, 1'b0, 1'b1);
    step(1'b1, 32'h1234_52B7, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("t6_out_valid", out_valid, 32'd0);
    check_eq("t6_counts", {compressed_count, total_count}, 32'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h1234_52B7, 1'b0, 1'b1);
    check_eq("t6_unpadded", out_word, 32'h1234_52B7);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("drained", 32'(wq.size() + hq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
